execution_sequencer: RTL and testbench

//  Parametrised fetch/decode/execute sequencer for the tau microcoded core; the next generation of the

---
 rtl/tau_exec_pkg.sv | 55 +++++
 rtl/exec_cycle_counter.sv | 29 ++
 rtl/execution_sequencer.sv | 119 +++++++++++
 tb/tb_execution_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/tau_exec_pkg.sv
// Shared types for the tau execution sequencer: FSM state encoding and the
// registered strobe vector with its per-state decode.
package tau_exec_pkg;

  typedef enum logic [2:0] {
    BOOT    = 3'd0,
    LOAD    = 3'd1,
    DECODE  = 3'd2,
    EXEC    = 3'd3,
    ADVANCE = 3'd4,
    JUMP    = 3'd5,
    HALT    = 3'd6,
    FAULT   = 3'd7
  } exec_state_t;

  typedef struct packed {
    logic useq_load_n;
    logic useq_enable;
    logic urom_read_enable;
    logic pc_enable;
    logic pc_load_n;
    logic fault;
  } exec_out_t;

  localparam exec_out_t IDLE_OUT = '{
    useq_load_n:      1'b1,
    useq_enable:      1'b0,
    urom_read_enable: 1'b0,
    pc_enable:        1'b0,
    pc_load_n:        1'b1,
    fault:            1'b0
  };

  function automatic exec_out_t decode_outputs(input exec_state_t s);
    exec_out_t o;
    o = IDLE_OUT;
    case (s)
      LOAD: begin
        o.useq_load_n      = 1'b0;
        o.urom_read_enable = 1'b1;
      end
      DECODE:  o.urom_read_enable = 1'b1;
      EXEC: begin
        o.useq_enable      = 1'b1;
        o.urom_read_enable = 1'b1;
      end
      ADVANCE: o.pc_enable = 1'b1;
      JUMP:    o.pc_load_n = 1'b0;
      FAULT:   o.fault     = 1'b1;
      default: o = IDLE_OUT;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/exec_cycle_counter.sv
// Falling-edge down-counter with parallel load and a zero flag; times both the
// boot delay and the PC-load window.
module exec_cycle_counter #(
  parameter int             W         = 2,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clock_i,
  input  logic         reset_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(negedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= RESET_VAL;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/execution_sequencer.sv
// Fetch/decode/execute sequencer for the tau microcoded core: Moore FSM on the
// falling clock edge with boot and jump timers and a per-instruction step watchdog.
module execution_sequencer
  import tau_exec_pkg::*;
#(
  parameter int  BOOT_CYCLES = 2,
  parameter int  JUMP_CYCLES = 1,
  parameter int  MAX_STEPS   = 16,
  localparam int STEP_W      = $clog2(MAX_STEPS + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              instr_finish,
  input  logic              halt,
  input  logic              resume,
  input  logic              jump_flag,
  output logic              useq_load_n,
  output logic              useq_enable,
  output logic              urom_read_enable,
  output logic              pc_enable,
  output logic              pc_load_n,
  output logic [STEP_W-1:0] step_count,
  output logic [2:0]        state_o,
  output logic              fault
);

  localparam int CNT_BJ  = (BOOT_CYCLES > JUMP_CYCLES) ? BOOT_CYCLES : JUMP_CYCLES;
  localparam int CNT_MAX = (CNT_BJ > MAX_STEPS) ? CNT_BJ : MAX_STEPS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS - 1);
  localparam logic [CNT_W-1:0]  JUMP_LD   = CNT_W'(JUMP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  BOOT_LD   = CNT_W'(BOOT_CYCLES);

  exec_state_t       state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  exec_out_t         out_q;
  logic              tmr_load, tmr_dec, tmr_zero;

  function automatic logic [STEP_W-1:0] inc_sat(input logic [STEP_W-1:0] v);
    return (v >= STEP_LAST) ? STEP_LAST : v + 1'b1;
  endfunction

  exec_cycle_counter #(
    .W         (CNT_W),
    .RESET_VAL (BOOT_LD)
  ) u_timer (
    .clock_i    (clock),
    .reset_n_i  (reset_n),
    .load_i     (tmr_load),
    .load_val_i (JUMP_LD),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    tmr_dec = 1'b0;
    if (enable) begin
      case (state_q)
        BOOT: begin
          if (tmr_zero) state_d = LOAD;
          else          tmr_dec = 1'b1;
        end
        LOAD: state_d = DECODE;
        DECODE: begin
          step_d = '0;
          if (halt)              state_d = HALT;
          else if (jump_flag)    state_d = JUMP;
          else if (instr_finish) state_d = ADVANCE;
          else                   state_d = EXEC;
        end
        EXEC: begin
          if (halt)                   state_d = HALT;
          else if (jump_flag)         state_d = JUMP;
          else if (instr_finish)      state_d = ADVANCE;
          else if (step_q == STEP_LAST) state_d = FAULT;
          else                        step_d  = inc_sat(step_q);
        end
        ADVANCE: state_d = halt ? HALT : LOAD;
        JUMP: begin
          // halt is only honoured once the load window has fully elapsed
          if (tmr_zero) state_d = halt ? HALT : LOAD;
          else          tmr_dec = 1'b1;
        end
        HALT:    if (resume && !halt) state_d = LOAD;
        FAULT:   state_d = FAULT;
        default: state_d = FAULT;
      endcase
    end
  end

  assign tmr_load = enable && (state_d == JUMP) && (state_q != JUMP);

  // Outputs are decoded from the next state so they move on the same edge as state
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BOOT;
      step_q  <= '0;
      out_q   <= IDLE_OUT;
    end else if (enable) begin
      state_q <= state_d;
      step_q  <= step_d;
      out_q   <= decode_outputs(state_d);
    end
  end

  assign useq_load_n      = out_q.useq_load_n;
  assign useq_enable      = out_q.useq_enable;
  assign urom_read_enable = out_q.urom_read_enable;
  assign pc_enable        = out_q.pc_enable;
  assign pc_load_n        = out_q.pc_load_n;
  assign fault            = out_q.fault;
  assign step_count       = step_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_execution_sequencer.sv
// Directed bench for execution_sequencer: stimulus pushes the expected state,
// strobes and step count per falling edge; a monitor pops and compares each cycle.
module tb_execution_sequencer;
  import tau_exec_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n, enable, instr_finish, halt, resume, jump_flag;
  logic       useq_load_n, useq_enable, urom_read_enable, pc_enable, pc_load_n, fault;
  logic [4:0] step_count;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;
  int cyc_id = 0;

  typedef struct packed {
    logic [2:0]  st;
    logic [4:0]  stp;
    logic [15:0] id;
  } exp_t;

  exp_t exp_q[$];

  execution_sequencer #(
    .BOOT_CYCLES (2),
    .JUMP_CYCLES (2),
    .MAX_STEPS   (16)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .enable           (enable),
    .instr_finish     (instr_finish),
    .halt             (halt),
    .resume           (resume),
    .jump_flag        (jump_flag),
    .useq_load_n      (useq_load_n),
    .useq_enable      (useq_enable),
    .urom_read_enable (urom_read_enable),
    .pc_enable        (pc_enable),
    .pc_load_n        (pc_load_n),
    .step_count       (step_count),
    .state_o          (state_o),
    .fault            (fault)
  );

  always #5 clock = ~clock;

  // {useq_load_n, useq_enable, urom_read_enable, pc_enable, pc_load_n, fault}
  function automatic logic [5:0] exp_outs(input logic [2:0] s);
    case (s)
      LOAD:    return 6'b001010;
      DECODE:  return 6'b101010;
      EXEC:    return 6'b111010;
      ADVANCE: return 6'b100110;
      JUMP:    return 6'b100000;
      FAULT:   return 6'b100011;
      default: return 6'b100010;
    endcase
  endfunction

  function automatic logic [13:0] actual_vec();
    return {state_o, useq_load_n, useq_enable, urom_read_enable,
            pc_enable, pc_load_n, fault, step_count};
  endfunction

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, want);
    end
  endtask

  // Entered at posedge+1; drives inputs sampled by the coming falling edge.
  task automatic cyc(input logic en, input logic fin, input logic hlt, input logic res,
                     input logic jmp, input exec_state_t st, input logic [4:0] stp);
    exp_t e;
    enable = en; instr_finish = fin; halt = hlt; resume = res; jump_flag = jmp;
    cyc_id++;
    e.st = st; e.stp = stp; e.id = 16'(cyc_id);
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    logic [13:0] act, want;
    forever begin
      @(posedge clock);
      if (exp_q.size() > 0) begin
        e    = exp_q.pop_front();
        act  = actual_vec();
        want = {e.st, exp_outs(e.st), e.stp};
        total++;
        if (act !== want) begin
          bad++;
          $display("FAIL cycle%0d: got state=%0d outs=%b step=%0d want state=%0d outs=%b step=%0d",
                   e.id, act[13:11], act[10:5], act[4:0], want[13:11], want[10:5], want[4:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset_n = 1'b0; enable = 1'b1; instr_finish = 1'b0;
    halt = 1'b0; resume = 1'b0; jump_flag = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_state", actual_vec(), {BOOT, 6'b100010, 5'd0});
    reset_n = 1'b1;

    // boot delay then single-cycle ops back to back
    cyc(1,1,0,0,0, BOOT,    0);
    cyc(1,1,0,0,0, BOOT,    0);
    cyc(1,1,0,0,0, LOAD,    0);
    cyc(1,1,0,0,0, DECODE,  0);
    cyc(1,1,0,0,0, ADVANCE, 0);
    cyc(1,1,0,0,0, LOAD,    0);
    cyc(1,1,0,0,0, DECODE,  0);
    cyc(1,1,0,0,0, ADVANCE, 0);
    cyc(1,1,0,0,0, LOAD,    0);
    // four-step op
    cyc(1,0,0,0,0, DECODE,  0);
    cyc(1,0,0,0,0, EXEC,    0);
    cyc(1,0,0,0,0, EXEC,    1);
    cyc(1,0,0,0,0, EXEC,    2);
    cyc(1,0,0,0,0, EXEC,    3);
    cyc(1,1,0,0,0, ADVANCE, 3);
    cyc(1,0,0,0,0, LOAD,    3);
    // jump together with finish; jump_flag left high into the next LOAD
    cyc(1,0,0,0,0, DECODE,  3);
    cyc(1,0,0,0,0, EXEC,    0);
    cyc(1,1,0,0,1, JUMP,    0);
    cyc(1,1,0,0,1, JUMP,    0);
    cyc(1,1,0,0,1, LOAD,    0);
    cyc(1,0,0,0,1, DECODE,  0);
    cyc(1,1,0,0,0, ADVANCE, 0);
    cyc(1,0,0,0,0, LOAD,    0);
    // halt in EXEC, resume ignored while halt high or outside HALT
    cyc(1,0,0,0,0, DECODE,  0);
    cyc(1,0,0,0,0, EXEC,    0);
    cyc(1,0,0,0,0, EXEC,    1);
    cyc(1,0,1,0,0, HALT,    1);
    cyc(1,0,1,1,0, HALT,    1);
    cyc(1,0,0,0,0, HALT,    1);
    cyc(1,0,0,1,0, LOAD,    1);
    cyc(1,0,0,1,0, DECODE,  1);
    cyc(1,1,1,0,1, HALT,    0);
    cyc(1,0,0,1,0, LOAD,    0);
    cyc(1,0,0,0,0, DECODE,  0);
    cyc(1,1,0,0,0, ADVANCE, 0);
    cyc(1,0,1,0,0, HALT,    0);
    cyc(1,0,0,1,0, LOAD,    0);
    // enable low mid-EXEC freezes everything
    cyc(1,0,0,0,0, DECODE,  0);
    cyc(1,0,0,0,0, EXEC,    0);
    cyc(1,0,0,0,0, EXEC,    1);
    cyc(1,0,0,0,0, EXEC,    2);
    for (int i = 0; i < 5; i++) cyc(0,1,1,1,1, EXEC, 2);
    cyc(1,0,0,0,0, EXEC,    3);
    cyc(1,1,0,0,0, ADVANCE, 3);
    cyc(1,0,0,0,0, LOAD,    3);
    // runaway instruction trips the watchdog
    cyc(1,0,0,0,0, DECODE,  3);
    cyc(1,0,0,0,0, EXEC,    0);
    for (int i = 1; i <= 15; i++) cyc(1,0,0,0,0, EXEC, 5'(i));
    cyc(1,0,0,0,0, FAULT,  15);
    cyc(1,0,0,1,0, FAULT,  15);
    cyc(1,1,1,0,1, FAULT,  15);

    reset_n = 1'b0;
    #1;
    chk("fault_cleared_by_reset", actual_vec(), {BOOT, 6'b100010, 5'd0});
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // reset asserted inside the jump window
    cyc(1,0,0,0,1, BOOT,    0);
    cyc(1,0,0,0,1, BOOT,    0);
    cyc(1,0,0,0,1, LOAD,    0);
    cyc(1,0,0,0,1, DECODE,  0);
    cyc(1,0,0,0,1, JUMP,    0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("reset_mid_jump", actual_vec(), {BOOT, 6'b100010, 5'd0});

    repeat (2) @(posedge clock);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
